// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [NIBBLE_W-1:0] BCD_ADJ_ADD    = 4'd3;
    localparam logic [NIBBLE_W-1:0] BLANK_CODE     = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: one BCD nibble, +3 when the digit is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit,
    output logic [NIBBLE_W-1:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Define BCD_BLANK_LEADING_ZEROS_EN to replace leading zero digits with BLANK_CODE.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [NIBBLE_W*DIGITS-1:0]   out_bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = NIBBLE_W * DIGITS;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   shift_reg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   next_scratch;
    logic [BCD_W-1:0]   final_bcd;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               last_shift;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (scratch[NIBBLE_W*k +: NIBBLE_W]),
            .adjusted (adjusted[NIBBLE_W*k +: NIBBLE_W])
        );
    end

    // The top scratch bit falls off here; only reachable with an undersized DIGITS.
    assign next_scratch = {adjusted[BCD_W-2:0], shift_reg[WIDTH-1]};

`ifdef BCD_BLANK_LEADING_ZEROS_EN
    logic seen_nonzero;

    // Scan from the top digit down; digit 0 always survives so zero shows as "0".
    always_comb begin
        final_bcd    = next_scratch;
        seen_nonzero = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (next_scratch[NIBBLE_W*k +: NIBBLE_W] != '0) begin
                seen_nonzero = 1'b1;
            end
            if (!seen_nonzero) begin
                final_bcd[NIBBLE_W*k +: NIBBLE_W] = BLANK_CODE;
            end
        end
    end
`else
    assign final_bcd = next_scratch;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = SHIFT;
            SHIFT:   if (count == CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        accept     = in_ready && in_valid;
        last_shift = (state == SHIFT) && (count == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                shift_reg <= in_data;
                scratch   <= '0;
                count     <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                scratch   <= next_scratch;
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                count     <= count - CNT_W'(1);
                if (last_shift) begin
                    out_bcd   <= final_bcd;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq (WIDTH=32, DIGITS=10).
// Expected values follow BCD_BLANK_LEADING_ZEROS_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_bcd;

    int vectors;
    int miscompares;

    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_BLANK_LEADING_ZEROS_EN
    localparam logic [39:0] EXP_1234 = 40'hFFFFFF1234;
    localparam logic [39:0] EXP_0    = 40'hFFFFFFFFF0;
    localparam logic [39:0] EXP_99   = 40'hFFFFFFFF99;
    localparam logic [39:0] EXP_100  = 40'hFFFFFFF100;
    localparam logic [39:0] EXP_7    = 40'hFFFFFFFFF7;
`else
    localparam logic [39:0] EXP_1234 = 40'h0000001234;
    localparam logic [39:0] EXP_0    = 40'h0000000000;
    localparam logic [39:0] EXP_99   = 40'h0000000099;
    localparam logic [39:0] EXP_100  = 40'h0000000100;
    localparam logic [39:0] EXP_7    = 40'h0000000007;
`endif
    localparam logic [39:0] EXP_MAX  = 40'h4294967295;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Present one value on the handshake and return #1 after the accept edge.
    task automatic applyStimulus(input logic [31:0] value);
        @(negedge clk);
        checkOutput("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = value;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges since the accept edge until out_valid is seen, bounded at 100.
    task automatic waitDone(input int start, output int lat);
        lat = start;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
    endtask

    // Checks one full conversion result and the single-cycle nature of out_valid.
    task automatic convertAndCheck(input string tag, input logic [31:0] value, input logic [39:0] expected);
        int lat;
        applyStimulus(value);
        waitDone(0, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd32);
        checkOutput({tag, "_bcd"}, 64'(out_bcd), 64'(expected));
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse_width"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_hold"}, 64'(out_bcd), 64'(expected));
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_bcd", 64'(out_bcd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countPulses(50, pulses);
        checkOutput("idle_no_valid", 64'(pulses), 64'd0);

        convertAndCheck("v1234", 32'd1234, EXP_1234);
        convertAndCheck("vmax", 32'hFFFFFFFF, EXP_MAX);
        convertAndCheck("vzero", 32'd0, EXP_0);

        // Back-to-back: the second value is offered in the out_valid cycle itself.
        applyStimulus(32'd99);
        waitDone(0, lat);
        checkOutput("b2b_99_latency", 64'(lat), 64'd32);
        checkOutput("b2b_99_bcd", 64'(out_bcd), 64'(EXP_99));
        checkOutput("b2b_ready_in_valid_cycle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'd100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("b2b_busy", 64'(in_ready), 64'd0);
        checkOutput("b2b_99_kept", 64'(out_bcd), 64'(EXP_99));
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'd12345;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("b2b_mid_kept", 64'(out_bcd), 64'(EXP_99));
        waitDone(6, lat);
        checkOutput("b2b_100_latency", 64'(lat), 64'd32);
        checkOutput("b2b_100_bcd", 64'(out_bcd), 64'(EXP_100));

        // A request while busy is dropped, not queued.
        applyStimulus(32'd7);
        repeat (9) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'd555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDone(10, lat);
        checkOutput("busy_latency", 64'(lat), 64'd32);
        checkOutput("busy_bcd", 64'(out_bcd), 64'(EXP_7));
        countPulses(50, pulses);
        checkOutput("busy_no_second", 64'(pulses), 64'd0);
        checkOutput("busy_bcd_after", 64'(out_bcd), 64'(EXP_7));

        // Reset mid-conversion takes effect without waiting for a clock edge.
        applyStimulus(32'd65535);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_bcd", 64'(out_bcd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countPulses(50, pulses);
        checkOutput("midrst_no_valid", 64'(pulses), 64'd0);
        checkOutput("midrst_bcd_after", 64'(out_bcd), 64'd0);

        convertAndCheck("after_rst", 32'd1234, EXP_1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
